// File: rtl/sat_acc_pkg.sv
// Shared types and constants for the saturating block accumulator.
package sat_acc_pkg;

    localparam int DEF_N   = 8;
    localparam int DEF_LEN = 4;
    localparam int MAX_W   = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Most-negative for sign=1, most-positive for sign=0; caller truncates to w bits.
    function automatic logic [MAX_W-1:0] sat_value(input logic sign, input int w);
        logic [MAX_W-1:0] msb;
        msb = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        return sign ? ~(msb - 1'b1) : (msb - 1'b1);
    endfunction

endpackage

// File: rtl/acc_add_stage.sv
// N-bit adder (carry-in 0) producing raw sum, unsigned carry and signed overflow.
module acc_add_stage
    import sat_acc_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] raw,
    output logic         c,
    output logic         v
);

    logic a;
    logic b;
    logic r;

    assign raw = a_in + b_in;
    assign a   = a_in[N-1];
    assign b   = b_in[N-1];
    assign r   = raw[N-1];

    assign c = (a & b) | (a & ~r) | (b & ~r);
    assign v = (a & b & ~r) | (~a & ~b & r);

endmodule

// File: rtl/sat_accumulator.sv
// Block accumulator of LEN signed samples with sticky carry/overflow flags.
// Saturation on signed overflow is enabled by SAT_ACCUMULATOR_SATURATE_EN.
module sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LEN = DEF_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_sum,
    output logic                     out_ovf,
    output logic                     out_carry,
    output logic [$clog2(LEN+1)-1:0] out_count
);

    localparam int CW = $clog2(LEN + 1);

    state_t        state;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          ovf_s;
    logic          carry_s;

    logic [N-1:0]  raw;
    logic [N-1:0]  next_acc;
    logic          c;
    logic          v;
    logic          accept;

    acc_add_stage #(.N(N)) u_add (
        .a_in (acc),
        .b_in (in_data),
        .raw  (raw),
        .c    (c),
        .v    (v)
    );

`ifdef SAT_ACCUMULATOR_SATURATE_EN
    assign next_acc = v ? N'(sat_value(acc[N-1], N)) : raw;
`else
    assign next_acc = raw;
`endif

    assign in_ready  = (state == ACCUM) & ~rst;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    assign out_sum   = acc;
    assign out_ovf   = ovf_s;
    assign out_carry = carry_s;
    assign out_count = cnt;

    // clear outranks both handshakes, including a sample offered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf_s   <= 1'b0;
            carry_s <= 1'b0;
        end else if (clear) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf_s   <= 1'b0;
            carry_s <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc     <= next_acc;
                        cnt     <= cnt + CW'(1);
                        ovf_s   <= ovf_s | v;
                        carry_s <= carry_s | c;
                        if (cnt == CW'(LEN - 1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf_s   <= 1'b0;
                        carry_s <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Self-checking bench for sat_accumulator (N=8, LEN=4) with a result scoreboard.
module tb_sat_accumulator;

    localparam int N   = 8;
    localparam int LEN = 4;
    localparam int CW  = $clog2(LEN + 1);

    typedef struct {
        logic [N-1:0]  sum;
        logic          ovf;
        logic          carry;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_ovf;
    logic          out_carry;
    logic [CW-1:0] out_count;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    logic [N-1:0]  m_acc;
    logic          m_ovf;
    logic          m_carry;
    int            m_cnt;

    sat_accumulator #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc   = '0;
        m_ovf   = 1'b0;
        m_carry = 1'b0;
        m_cnt   = 0;
    endtask

    // Integer-arithmetic reference for one accepted sample
    task automatic model_add(input logic [N-1:0] x);
        int s;
        int u;
        exp_t e;
        s = int'($signed(m_acc)) + int'($signed(x));
        u = int'(m_acc) + int'(x);
        if (u > 255) m_carry = 1'b1;
        if (s > 127 || s < -128) begin
            m_ovf = 1'b1;
`ifdef SAT_ACCUMULATOR_SATURATE_EN
            s = (s > 127) ? 127 : -128;
`endif
        end
        m_acc = N'(s);
        m_cnt++;
        if (m_cnt == LEN) begin
            e.sum   = m_acc;
            e.ovf   = m_ovf;
            e.carry = m_carry;
            e.count = CW'(LEN);
            sb.push_back(e);
            model_reset();
        end
    endtask

    task automatic send_sample(input logic [N-1:0] x);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) model_add(x);
    endtask

    // Called straight after the last sample's handshake edge
    task automatic pop_result(input string name, input bit expect_drain);
        exp_t e;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b required 1", name, out_valid);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb_empty: size=0 required >0", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (out_sum !== e.sum) begin
            errors++;
            $display("FAIL %s_sum: got %h required %h", name, out_sum, e.sum);
        end
        checks++;
        if (out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s_ovf: got %b required %b", name, out_ovf, e.ovf);
        end
        checks++;
        if (out_carry !== e.carry) begin
            errors++;
            $display("FAIL %s_carry: got %b required %b", name, out_carry, e.carry);
        end
        checks++;
        if (out_count !== e.count) begin
            errors++;
            $display("FAIL %s_count: got %0d required %0d", name, out_count, e.count);
        end
        if (expect_drain) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_one_cycle: out_valid=%b in_ready=%b required 0/1",
                         name, out_valid, in_ready);
            end
        end
    endtask

    task automatic send_block(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] c, input logic [N-1:0] d);
        send_sample(a);
        send_sample(b);
        send_sample(c);
        send_sample(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_carry, out_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%h/%b/%b/%0d required all 0",
                     in_ready, out_valid, out_sum, out_ovf, out_carry, out_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_plain_sum();
        send_block(8'd10, 8'd20, 8'd30, 8'd40);
        pop_result("plain", 1'b1);
    endtask

    task automatic test_pos_overflow();
        send_block(8'd64, 8'd64, 8'd0, 8'd0);
        pop_result("pos_ovf", 1'b1);
    endtask

    task automatic test_neg_overflow();
        send_block(8'h80, 8'hFF, 8'd0, 8'd0);
        pop_result("neg_ovf", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] held;
        out_ready = 1'b0;
        send_block(8'd5, 8'd6, 8'd7, 8'd8);
        pop_result("bp", 1'b0);
        held = out_sum;
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held ||
                out_count !== CW'(LEN)) begin
                errors++;
                $display("FAIL bp_hold: rdy=%b vld=%b sum=%h cnt=%0d required 0/1/%h/%0d",
                         in_ready, out_valid, out_sum, out_count, held, LEN);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b vld=%b cnt=%0d required 1/0/0",
                     in_ready, out_valid, out_count);
        end
        send_block(8'd1, 8'd2, 8'd3, 8'd4);
        pop_result("bp_next", 1'b1);
    endtask

    task automatic test_clear();
        send_sample(8'd100);
        send_sample(8'd100);
        checks++;
        if (out_count !== CW'(2)) begin
            errors++;
            $display("FAIL clear_pre_count: got %0d required 2", out_count);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd5;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        checks++;
        if (out_count !== '0 || out_sum !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: cnt=%0d sum=%h ovf=%b required 0/00/0",
                     out_count, out_sum, out_ovf);
        end
        send_block(8'd1, 8'd1, 8'd1, 8'd1);
        pop_result("clear_next", 1'b1);
    endtask

    task automatic test_async_reset();
        send_sample(8'd50);
        send_sample(8'd60);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_carry, out_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%h/%b/%b/%0d required all 0",
                     in_ready, out_valid, out_sum, out_ovf, out_carry, out_count);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_block(8'd7, 8'd7, 8'd7, 8'd7);
        pop_result("post_reset", 1'b1);
    endtask

    initial begin
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_plain_sum();
        test_pos_overflow();
        test_neg_overflow();
        test_back_to_back();
        test_clear();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: size=%0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
